// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_W    = 16;
  localparam int DIV_ITER = 16;
  localparam int DIV_LAT  = 18;

endpackage

// File: rtl/div_step.sv
// One combinational restoring iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dq,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] dq_next
);

  logic [W-1:0] part;
  logic [W:0]   trial;
  // The partial remainder stays below 2^(W-1) until the final step, so its MSB never carries information.
  logic         unused_rem_msb;

  assign unused_rem_msb = rem[W-1];
  assign part  = {rem[W-2:0], dq[W-1]};
  assign trial = {1'b0, part} - {1'b0, dvs};

  always_comb begin
    rem_next = part;
    dq_next  = {dq[W-2:0], 1'b0};
    if (!trial[W]) begin
      rem_next = trial[W-1:0];
      dq_next  = {dq[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential 16-bit restoring divider with start/busy/done handshake, fixed 18-cycle latency.
// Define DIV_SIGNED_EN to honour is_signed (truncating signed division) and enable ovfl.
module div_seq
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         is_signed,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_zero,
  output logic         ovfl
);

  localparam int CW = $clog2(DIV_ITER);

  div_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic         accept;

  logic [W-1:0] rem, dq, dvs_mag, dvd_raw;
  logic [W-1:0] rem_nxt, dq_nxt;
  logic         dvs_zero;

  logic [W-1:0] dvd_mag_in, dvs_mag_in, q_fix, r_fix;
  logic         ovfl_in;

  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == RUN) || (state == FIX);
  assign done   = (state == DONE);

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r, ovfl_cap;

  function automatic logic [W-1:0] negate(input logic [W-1:0] v);
    return (~v) + {{(W-1){1'b0}}, 1'b1};
  endfunction

  assign dvd_mag_in = (is_signed && dividend[W-1]) ? negate(dividend) : dividend;
  assign dvs_mag_in = (is_signed && divisor[W-1])  ? negate(divisor)  : divisor;

  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q    <= is_signed && (dividend[W-1] ^ divisor[W-1]);
      neg_r    <= is_signed && dividend[W-1];
      ovfl_cap <= is_signed && (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == '1);
    end
  end

  assign q_fix   = neg_q ? negate(dq)  : dq;
  assign r_fix   = neg_r ? negate(rem) : rem;
  assign ovfl_in = ovfl_cap;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dvd_mag_in = dividend;
  assign dvs_mag_in = divisor;
  assign q_fix      = dq;
  assign r_fix      = rem;
  assign ovfl_in    = 1'b0;
`endif

  div_step #(.W(W)) u_step (
    .rem      (rem),
    .dq       (dq),
    .dvs      (dvs_mag),
    .rem_next (rem_nxt),
    .dq_next  (dq_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CW'(DIV_ITER - 1);
      else if (state == RUN)
        cnt <= cnt - 1'b1;
    end
  end

  // Operand capture and iteration; working registers need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem      <= '0;
      dq       <= dvd_mag_in;
      dvs_mag  <= dvs_mag_in;
      dvd_raw  <= dividend;
      dvs_zero <= (divisor == '0);
    end else if (state == RUN) begin
      rem <= rem_nxt;
      dq  <= dq_nxt;
    end
  end

  // Results load on the FIX edge and hold until the next operation completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovfl      <= 1'b0;
    end else if (state == FIX) begin
      quotient  <= dvs_zero ? dq      : q_fix;
      remainder <= dvs_zero ? dvd_raw : r_fix;
      div_zero  <= dvs_zero;
      ovfl      <= ovfl_in;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table, handshake corner cases, randomized model check.
module tb_div_seq;
  import div_pkg::*;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, is_signed;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_zero, ovfl;
  logic [15:0] quotient, remainder;

  int n_chk = 0;
  int n_fail = 0;

  div_seq #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovfl      (ovfl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Spec-level reference: plain integer division with truncation.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov);
    bit se;
    int ia, ib;
    se = s && SIGNED_EN;
    dz = (b == 16'h0);
    ov = se && (a == 16'h8000) && (b == 16'hFFFF);
    if (dz) begin
      q = 16'hFFFF;
      r = a;
    end else if (se) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
      q  = 16'(ia / ib);
      r  = 16'(ia % ib);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Starts at a negedge, returns at the negedge where done is seen (or on timeout).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output int lat, output int bcnt);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  task automatic chk_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                            input logic dz, input logic ov, input int lat);
    chk({tag, "_latency"}, lat, DIV_LAT);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_quot"}, quotient, q);
    chk({tag, "_rem"}, remainder, r);
    chk({tag, "_dz"}, div_zero, dz);
    chk({tag, "_ovfl"}, ovfl, ov);
  endtask

  initial begin
    int lat, bcnt, dcnt;
    logic [15:0] a, b, q, r;
    logic s, dz, ov;

    vecs[0] = '{16'd100,  16'd7,      1'b0, 16'd14,     16'd2,     1'b0, 1'b0};
    vecs[3] = '{16'd1234, 16'd0,      1'b0, 16'hFFFF,   16'd1234,  1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 16'd1,      1'b0, 16'hFFFF,   16'd0,     1'b0, 1'b0};
    vecs[5] = '{16'd50,   16'd5,      1'b0, 16'd10,     16'd0,     1'b0, 1'b0};
    vecs[8] = '{16'hFFF9, 16'd0,      1'b1, 16'hFFFF,   16'hFFF9,  1'b1, 1'b0};
`ifdef DIV_SIGNED_EN
    vecs[1] = '{16'hFF9C, 16'h0007,   1'b1, 16'hFFF2,   16'hFFFE,  1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'hFFFF,   1'b1, 16'h8000,   16'h0000,  1'b0, 1'b1};
    vecs[6] = '{16'h0007, 16'hFFFE,   1'b1, 16'hFFFD,   16'h0001,  1'b0, 1'b0};
    vecs[7] = '{16'hFFF9, 16'hFFFE,   1'b1, 16'h0003,   16'hFFFF,  1'b0, 1'b0};
`else
    vecs[1] = '{16'hFF9C, 16'h0007,   1'b1, 16'h2484,   16'h0000,  1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'hFFFF,   1'b1, 16'h0000,   16'h8000,  1'b0, 1'b0};
    vecs[6] = '{16'h0007, 16'hFFFE,   1'b1, 16'h0000,   16'h0007,  1'b0, 1'b0};
    vecs[7] = '{16'hFFF9, 16'hFFFE,   1'b1, 16'h0000,   16'hFFF9,  1'b0, 1'b0};
`endif

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quot", quotient, 16'h0);
    chk("rst_rem", remainder, 16'h0);
    chk("rst_dz", div_zero, 1'b0);
    chk("rst_ovfl", ovfl, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat, bcnt);
      chk_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov, lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 17);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), done, 1'b0);
      chk($sformatf("vec%0d_hold_quot", i), quotient, vecs[i].q);
      @(negedge clk);
    end

    // Start pulsed during RUN must be ignored.
    dividend = 16'hFFFF; divisor = 16'd1; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    repeat (3) begin @(negedge clk); lat++; end
    dividend = 16'd5; divisor = 16'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk_result("ignore_start", 16'hFFFF, 16'h0, 1'b0, 1'b0, lat);
    @(negedge clk);

    // Reset during RUN aborts the operation.
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_quot", quotient, 16'h0);
    chk("abort_rem", remainder, 16'h0);
    chk("abort_dz", div_zero, 1'b0);
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    // Back-to-back starts accepted in DONE.
    run_op(16'd50, 16'd5, 1'b0, lat, bcnt);
    chk_result("b2b_first", 16'd10, 16'd0, 1'b0, 1'b0, lat);
    run_op(16'd9, 16'd4, 1'b0, lat, bcnt);
    chk_result("b2b_second", 16'd2, 16'd1, 1'b0, 1'b0, lat);
    @(negedge clk);

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = 16'h0;
        1: b = 16'($urandom_range(1, 9));
        2: begin a = 16'h8000; b = 16'hFFFF; s = 1'b1; end
        3: b = {8'hFF, 8'($urandom)};
        default: ;
      endcase
      model(a, b, s, q, r, dz, ov);
      run_op(a, b, s, lat, bcnt);
      chk_result($sformatf("rand%0d_%h_%h_%0d", n, a, b, s), q, r, dz, ov, lat);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential 16-bit restoring divider for the phase3 datapath. It is the iterative counterpart to the single-cycle add/sub unit and computes quotient and remainder one bit per clock. A start/busy/done handshake stalls the pipeline for the fixed latency. Signed operation follows truncation semantics, and divide-by-zero and signed-overflow flags are reported alongside the result.

## Interface
Parameters:
- W, 16: operand and result width; only 16 is verified.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request a division; sampled only in IDLE or DONE
- dividend  in  W  numerator, captured on the accepted start edge
- divisor  in  W  denominator, captured on the accepted start edge
- is_signed  in  1  two's-complement operation when 1, captured with the operands
- busy  out  1  high in RUN and FIX
- done  out  1  one-cycle pulse in DONE; results valid from this cycle
- quotient  out  W  result quotient
- remainder  out  W  result remainder
- div_zero  out  1  divisor was 0 for the current result
- ovfl  out  1  signed 0x8000 / 0xFFFF occurred for the current result

## Operation
- States: IDLE, RUN, FIX, DONE.
- Accepting a start, from IDLE or DONE:
  - Capture the operands.
  - Form magnitudes when signed: the negated value if the MSB is set, otherwise the raw value.
  - Clear the partial remainder, load the iteration counter with 15, and go to RUN.
- RUN, one restoring step per cycle:
  - Partial remainder = {rem[W-2:0], dq[W-1]}.
  - Trial = partial remainder - magnitude divisor.
  - If trial ≥ 0: rem ← trial and shift in quotient bit 1. Otherwise keep the partial remainder and shift in 0.
  - Counter decrements each cycle; when the counter is 0, go to FIX.
- FIX:
  - Signed: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - div_zero: skip all sign correction. The quotient is 16'hFFFF and the remainder is the raw dividend, which is the natural restoring result.
  - Go to DONE.
- DONE:
  - done=1 and outputs registered.
  - Accepting a start goes straight to RUN; otherwise go to IDLE.
- Results and flags hold until the next accepted start. They are not cleared on the transition DONE→IDLE.
- ovfl: set when is_signed and dividend=0x8000 and divisor=0xFFFF. The quotient is 0x8000 and the remainder is 0, produced by the unsigned path with no special case.
- start while busy is ignored, and operands are not re-captured.
- Unsigned mode: no magnitude conversion or sign fix; ovfl is always 0.

## Timing
- Reset values: state IDLE, busy 0, done 0, quotient 0, remainder 0, div_zero 0, ovfl 0.
- Latency: start accepted at edge k.
  - RUN covers cycles k+1..k+16.
  - FIX is cycle k+17.
  - DONE (done=1) is cycle k+18.
- Latency is fixed for every operand value, including a zero divisor.
- Throughput: back-to-back starts in DONE give one result every 18 cycles.
- rst_n low at any edge aborts immediately. All outputs take their reset values at that edge, and no done is produced for the aborted operation.
- If rst_n is low and start is high on the same edge, reset wins.

## Configuration
- DIV_SIGNED_EN defined: is_signed is honored and ovfl is live.
- DIV_SIGNED_EN undefined:
  - The is_signed port remains but is ignored; all operations are unsigned.
  - ovfl is tied to 0.
  - Magnitude and FIX sign logic is removed. FIX remains as a one-cycle pass-through, so latency is unchanged.

## Structure
- Shared package div_pkg holds:
  - the state enum: IDLE, RUN, FIX, DONE;
  - the DIV_W=16 constant;
  - the DIV_ITER=16 constant;
  - the DIV_LAT=18 constant.
- One sub-module, div_step, is the combinational single restoring iteration:
  - inputs: partial remainder, quotient shift register, divisor magnitude;
  - outputs: next remainder and next quotient.
- The FSM, counter and sign logic live in div_seq.

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2, done exactly 18 cycles after start, busy high for 17 cycles.
- Signed -100 / 7 (0xFF9C / 0x0007) → quotient 0xFFF2, remainder 0xFFFE, ovfl 0, div_zero 0.
- Signed 0x8000 / 0xFFFF → quotient 0x8000, remainder 0, ovfl 1.
- Unsigned 1234 / 0 → quotient 0xFFFF, remainder 1234, div_zero 1, latency 18.
- 0xFFFF / 1 unsigned, with a second start pulsed at RUN cycle 3 → second start ignored; result quotient 0xFFFF, remainder 0.
- rst_n low at RUN cycle 5 → next cycle busy 0, all outputs 0, no done pulse.
- Back-to-back start in DONE: 50 / 5 then 9 / 4 → done pulses 18 cycles apart, results 10 r0 then 2 r1.
